// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use hazards, branch squash,
// multi-cycle mul/div freeze, plus a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IdExMemRead,
    input  logic [4:0]       IdExRt,
    input  logic [31:0]      instr2,
    input  logic             branchTaken,
    input  logic             exMdStart,
    input  logic             statClr,
    output logic             PcWrite,
    output logic             IFIDWrite,
    output logic             IdExWrite,
    output logic             sel,
    output logic             IFIDFlush,
    output logic             exMemBubble,
    output logic             mdBusy,
    output logic             mdDone,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic {
        RUN    = 1'b0,
        MDWAIT = 1'b1
    } state_t;

    // cnt only ever holds MD_CYCLES-2 down to 0
    localparam int CW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MD_CYCLES - 2);

    state_t        state;
    logic [CW-1:0] cnt;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       hz;
    logic       unusedInstrBits;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign op              = instr2[31:26];
    assign rs              = instr2[25:21];
    assign rt              = instr2[20:16];
    assign unusedInstrBits = ^instr2[15:0];
    assign usesRt          = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    assign hz              = IdExMemRead && (IdExRt != 5'd0) &&
                             ((IdExRt == rs) || (usesRt && (IdExRt == rt)));

    always_comb begin
        PcWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IdExWrite   = 1'b1;
        sel         = 1'b1;
        IFIDFlush   = 1'b0;
        exMemBubble = 1'b0;
        mdBusy      = 1'b0;
        mdDone      = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (branchTaken) begin
                        IFIDFlush = 1'b1;
                        sel       = 1'b0;
                    end else if (exMdStart) begin
                        PcWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IdExWrite   = 1'b0;
                        exMemBubble = 1'b1;
                        mdBusy      = 1'b1;
                    end else if (hz) begin
                        PcWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        sel       = 1'b0;
                    end
                end
                MDWAIT: begin
                    if (cnt != '0) begin
                        PcWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IdExWrite   = 1'b0;
                        exMemBubble = 1'b1;
                        mdBusy      = 1'b1;
                    end else begin
                        // result lands while the instruction behind may still need a load-use bubble
                        mdDone = 1'b1;
                        if (hz) begin
                            PcWrite   = 1'b0;
                            IFIDWrite = 1'b0;
                            sel       = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            stallCount <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!branchTaken && exMdStart) begin
                        state <= MDWAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                MDWAIT: begin
                    if (cnt == '0) state <= RUN;
                    else           cnt   <= cnt - CW'(1);
                end
                default: state <= RUN;
            endcase
            if (statClr)       stallCount <= '0;
            else if (!PcWrite) stallCount <= satInc(stallCount);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a cycle-level reference model pushes
// expected outputs; an independent monitor pops and compares on the falling edge.
module tb_pipeline_stall_ctrl;

    localparam int MD_CYCLES = 4;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             IdExMemRead = 1'b0;
    logic [4:0]       IdExRt = '0;
    logic [31:0]      instr2 = '0;
    logic             branchTaken = 1'b0;
    logic             exMdStart = 1'b0;
    logic             statClr = 1'b0;
    logic             PcWrite, IFIDWrite, IdExWrite, sel, IFIDFlush;
    logic             exMemBubble, mdBusy, mdDone;
    logic [CNT_W-1:0] stallCount;

    pipeline_stall_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .IdExMemRead(IdExMemRead), .IdExRt(IdExRt),
        .instr2(instr2), .branchTaken(branchTaken), .exMdStart(exMdStart),
        .statClr(statClr), .PcWrite(PcWrite), .IFIDWrite(IFIDWrite),
        .IdExWrite(IdExWrite), .sel(sel), .IFIDFlush(IFIDFlush),
        .exMemBubble(exMemBubble), .mdBusy(mdBusy), .mdDone(mdDone),
        .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcW, ifidW, idexW, sel, flush, bub, busy, done;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference model state: mul/div in flight and cycles elapsed since it started
    bit   mdOn     = 1'b0;
    int   mdAge    = 0;
    int   modelCnt = 0;

    function automatic bit refHazard(input bit mr, input logic [4:0] dst, input logic [31:0] ins);
        int opc, srcS, srcT;
        bit readsRt;
        opc     = int'(ins[31:26]);
        srcS    = int'(ins[25:21]);
        srcT    = int'(ins[20:16]);
        readsRt = (opc == 0) || (opc == 4) || (opc == 5) || (opc == 'h2B);
        if (!mr || dst == 5'd0) return 1'b0;
        return (int'(dst) == srcS) || (readsRt && int'(dst) == srcT);
    endfunction

    task automatic step(input bit r, input bit mr, input logic [4:0] dst,
                        input logic [31:0] ins, input bit bt, input bit md, input bit clr);
        exp_t e;
        bit   h;
        @(posedge clk);
        #1;
        rst = r; IdExMemRead = mr; IdExRt = dst; instr2 = ins;
        branchTaken = bt; exMdStart = md; statClr = clr;
        h = refHazard(mr, dst, ins);
        e = '0;
        e.pcW = 1'b1; e.ifidW = 1'b1; e.idexW = 1'b1; e.sel = 1'b1;
        if (r) begin
            mdOn     = 1'b0;
            modelCnt = 0;
        end else if (mdOn) begin
            if (mdAge < MD_CYCLES - 1) begin
                e.pcW = 1'b0; e.ifidW = 1'b0; e.idexW = 1'b0; e.bub = 1'b1; e.busy = 1'b1;
            end else begin
                e.done = 1'b1;
                mdOn   = 1'b0;
                if (h) begin e.pcW = 1'b0; e.ifidW = 1'b0; e.sel = 1'b0; end
            end
        end else if (bt) begin
            e.flush = 1'b1; e.sel = 1'b0;
        end else if (md) begin
            e.pcW = 1'b0; e.ifidW = 1'b0; e.idexW = 1'b0; e.bub = 1'b1; e.busy = 1'b1;
            mdOn  = 1'b1;
            mdAge = 0;
        end else if (h) begin
            e.pcW = 1'b0; e.ifidW = 1'b0; e.sel = 1'b0;
        end
        e.cnt = CNT_W'(modelCnt);
        q.push_back(e);
        if (!r) begin
            if (clr) modelCnt = 0;
            else if (!e.pcW && modelCnt < CNT_MAX) modelCnt++;
            if (mdOn) mdAge++;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [4:0] rndReg();
        return ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(7, 10));
    endfunction

    // monitor
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {PcWrite, IFIDWrite, IdExWrite, sel, IFIDFlush, exMemBubble,
                     mdBusy, mdDone, stallCount};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got pc=%b ifid=%b idex=%b sel=%b flush=%b bub=%b busy=%b done=%b cnt=%0d required pc=%b ifid=%b idex=%b sel=%b flush=%b bub=%b busy=%b done=%b cnt=%0d",
                             $time, a.pcW, a.ifidW, a.idexW, a.sel, a.flush, a.bub, a.busy, a.done, a.cnt,
                             e.pcW, e.ifidW, e.idexW, e.sel, e.flush, e.bub, e.busy, e.done, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [31:0] ins;
        int          ops[7];
        ops = '{0, 4, 5, 'h2B, 8, 'h23, 'h0D};

        step(1'b1, 1'b1, 5'd8, 32'h010A_4820, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();

        // load-use through rs, then the load advances
        step(1'b0, 1'b1, 5'd8, 32'h010A_4820, 1'b0, 1'b0, 1'b0);
        idle();
        // $0 destination and non-source rt never stall
        step(1'b0, 1'b1, 5'd0, 32'h0000_4820, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd8, 32'h2068_0005, 1'b0, 1'b0, 1'b0);
        // rt is a source for sw
        step(1'b0, 1'b1, 5'd8, 32'hAC68_0000, 1'b0, 1'b0, 1'b0);
        // branch wins over a simultaneous hazard
        step(1'b0, 1'b1, 5'd8, 32'h010A_4820, 1'b1, 1'b0, 1'b0);
        idle();
        // single mul/div pulse
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (5) idle();
        // exMdStart held for the whole operation still yields one sequence
        repeat (MD_CYCLES) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) idle();
        // hazard coinciding with mdDone
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (MD_CYCLES - 2) idle();
        step(1'b0, 1'b1, 5'd9, 32'h0129_5020, 1'b0, 1'b0, 1'b0);
        idle();
        // reset mid-MDWAIT: no mdDone afterwards
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
        repeat (5) idle();

        for (int i = 0; i < 3000; i++) begin
            ins = {6'(ops[$urandom_range(0, 6)]), rndReg(), rndReg(), 16'($urandom)};
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), rndReg(), ins,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        // saturation under a permanent hazard, then clear beats increment
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (65600) step(1'b0, 1'b1, 5'd8, 32'h010A_4820, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (stallCount !== 16'hFFFF) begin
            failures++;
            $display("FAIL saturate got=%h required=ffff", stallCount);
        end
        step(1'b0, 1'b1, 5'd8, 32'h010A_4820, 1'b0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        checks++;
        if (stallCount !== 16'h0000) begin
            failures++;
            $display("FAIL clear got=%h required=0000", stallCount);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It merges three sources of pipeline control:
- load-use hazards between the IF/ID instruction and a load in ID/EX;
- taken-branch squashes resolved in EX;
- a multi-cycle mul/div unit that holds EX for several cycles.

From these it drives the PC, IF/ID and ID/EX write enables, the ID/EX bubble mux select, the IF/ID flush and the EX/MEM bubble. It also keeps a stall-cycle performance counter.

Parameters:
- MD_CYCLES, 4, total cycles a mul/div occupies EX (legal range >= 2).
- CNT_W, 16, width of stallCount.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- IdExMemRead  input  1  instruction in ID/EX is a load.
- IdExRt  input  5  destination rt of the instruction in ID/EX.
- instr2  input  32  instruction word held in IF/ID.
- branchTaken  input  1  branch in EX resolved taken this cycle.
- exMdStart  input  1  instruction in EX is mult/div, first EX cycle.
- statClr  input  1  synchronous clear of stallCount.
- PcWrite  output  1  PC load enable.
- IFIDWrite  output  1  IF/ID load enable.
- IdExWrite  output  1  ID/EX load enable.
- sel  output  1  1 = pass control into ID/EX; 0 = insert bubble.
- IFIDFlush  output  1  clear IF/ID to a NOP on the next edge.
- exMemBubble  output  1  load a bubble into EX/MEM.
- mdBusy  output  1  mul/div is stalling the pipeline.
- mdDone  output  1  mul/div result is valid this cycle.
- stallCount  output  CNT_W  number of cycles with PcWrite == 0.

Behaviour:
- Decode: rs = instr2[25:21], rt = instr2[20:16], op = instr2[31:26].
- usesRt = 1 when op is 0x00, 0x04, 0x05 or 0x2B; otherwise usesRt = 0.
- hz = IdExMemRead && IdExRt != 0 && (IdExRt == rs || (usesRt && IdExRt == rt)).
- $0 never causes a hazard.
- FSM state is held in a register updated on posedge clk. Control outputs are a combinational decode of the current state and the current inputs.
- Default outputs: PcWrite = 1, IFIDWrite = 1, IdExWrite = 1, sel = 1, IFIDFlush = 0, exMemBubble = 0, mdBusy = 0, mdDone = 0.
- State RUN, evaluated in priority order:
  1. branchTaken: IFIDFlush = 1 and sel = 0; PC loads the branch target. Any hz in the same cycle is ignored.
  2. exMdStart: PcWrite = 0, IFIDWrite = 0, IdExWrite = 0, exMemBubble = 1, mdBusy = 1. Next state is MDWAIT with cnt <= MD_CYCLES-2.
  3. hz: PcWrite = 0, IFIDWrite = 0, sel = 0, for exactly one cycle; the load then advances and hz drops.
  4. Otherwise: default outputs.
- State MDWAIT:
  - cnt != 0: freeze outputs as in RUN case 2; cnt decrements.
  - cnt == 0: mdDone = 1, write enables released, next state RUN. The load-use check applies as in RUN case 3.
  - branchTaken and exMdStart are ignored in MDWAIT.
- Mul/div timing: the pipeline is frozen for exactly MD_CYCLES-1 cycles. mdDone asserts in the MD_CYCLES-th cycle after exMdStart.
- stallCount:
  - Increments on every posedge where PcWrite == 0.
  - Saturates at all-ones.
  - statClr forces it to 0 and wins over a simultaneous increment.
- Reset (asynchronous, at any time including mid-MDWAIT):
  - state = RUN, cnt = 0, stallCount = 0.
  - While rst is high, outputs are forced to defaults regardless of inputs.
  - No mdDone is issued for an operation aborted by reset.

Test Plan:
1. IdExMemRead = 1, IdExRt = 8, instr2 = add $9,$8,$10 (0x010A4820) -> PcWrite = 0, IFIDWrite = 0, sel = 0 for 1 cycle, then defaults; stallCount 0 -> 1.
2. IdExMemRead = 1, IdExRt = 0 with rs = 0 -> no stall. IdExRt = 8 with instr2 = addi $8,$3,5 (0x20680005) -> no stall, because rt is not a source.
3. branchTaken = 1 and a case-1 hazard in the same cycle -> IFIDFlush = 1, sel = 0, PcWrite = 1, IFIDWrite = 1; stallCount unchanged.
4. exMdStart pulse with MD_CYCLES = 4 -> freeze and exMemBubble for 3 cycles, mdDone = 1 on the 4th cycle, stallCount += 3. exMdStart held high throughout -> still exactly one sequence.
5. rst pulsed while in MDWAIT with cnt = 1 -> outputs go to defaults immediately, stallCount = 0; no mdDone follows after rst drops.
6. Hold hz true for 70000 cycles -> stallCount saturates at 0xFFFF. Then assert statClr together with a stall -> stallCount = 0.
